output_write_arbiter: RTL and testbench
=======================================

Name: output_write_arbiter

Overview:
- Shares the single output-DMA write path between NUM_REQ result producers, e.g. the conv, pool and FC engines.
- The shared path is the FIFO-backed AXI burst writer driven by length, base address, wr_en/din and done.
- Grants one producer at a time in round-robin order and latches that producer's job descriptor (length, base address) onto the writer.
- Forwards the producer's word stream, waits for the writer's done, then acknowledges the producer.

Parameters:
- NUM_REQ, 3, number of producers.
- LEN_W, 11, job length width. Length is encoded as words-1.
- ADDR_W, 32, base address width.
- DATA_W, 32, data word width.
- TIMEOUT, 65535, maximum cycles spent in WAIT_DONE before the job is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-producer job request, held until the matching req_done.
- req_len  in  NUM_REQ*LEN_W  per-producer word count minus 1; slice i = bits [i*LEN_W +: LEN_W].
- req_addr  in  NUM_REQ*ADDR_W  per-producer destination base address.
- req_wr_en  in  NUM_REQ  per-producer data valid.
- req_din  in  NUM_REQ*DATA_W  per-producer data.
- grant  out  NUM_REQ  one-hot, registered.
- req_done  out  NUM_REQ  one-cycle acknowledge pulse.
- out_len  out  LEN_W  to writer Output_Len.
- out_base_addr  out  ADDR_W  to writer Matrix_Base_Addr.
- out_wr_en  out  1  to writer FIFO wr_en.
- out_din  out  DATA_W  to writer FIFO din.
- out_done  in  1  writer done pulse.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  pulse: granted producer sent a word beyond its length.
- timeout_err  out  1  pulse: out_done missing for TIMEOUT cycles.

Behaviour:
- Reset: asynchronous and active-low. Every register clears immediately on rst_n low, including mid-job:
  - FSM to IDLE, round-robin pointer to 0, word count 0;
  - all outputs 0.
  - Any partially forwarded job is abandoned with no req_done.
- States and transitions:
  - IDLE: if any req bit is high, pick the first set bit at or after rr_ptr, scanning with wrap. Register grant, out_len and out_base_addr from that slice. Clear word_cnt. Go to STREAM. Grant is high the cycle after req is seen.
  - STREAM:
    - Forwarding is registered with 1-cycle latency: out_wr_en = req_wr_en[g] and out_din = req_din[g], both delayed one cycle.
    - word_cnt increments on each accepted word.
    - The word with word_cnt == out_len is the last one; after accepting it, go to WAIT_DONE.
    - req_wr_en from non-granted producers is ignored; those producers must stall on grant.
  - WAIT_DONE:
    - out_done high → RELEASE.
    - timer reaches TIMEOUT → RELEASE with timeout_err pulsed for one cycle.
    - Words from the granted producer are dropped (out_wr_en stays 0) and overflow pulses for one cycle per word.
  - RELEASE: pulse req_done[g] for one cycle, set rr_ptr = g+1 with wrap to 0, clear grant. Go to IDLE. The next grant comes no earlier than the cycle after RELEASE.
- out_len and out_base_addr stay stable from the grant until RELEASE; the writer samples them at any time in that window.
- out_done arriving while in STREAM is ignored and logged as a protocol violation in the assertions.
- out_len = 0 is a legal single-word job.
- Maximum job is 2^LEN_W words; word_cnt is LEN_W bits and never wraps inside a job.
- Producers changing req_len or req_addr while granted has no effect, because both are latched.
- A req dropped while granted does not abort the job.

Test Plan:
- Single producer 1: req[1]=1, len=3, addr=0x1000, 4 words D0..D3.
  - grant=3'b010 one cycle after req, out_len=3, out_base_addr=0x1000.
  - out_wr_en pulses 4 times, each one cycle after its input word.
  - out_done pulse → req_done[1] pulse, busy low the following cycle.
- Round-robin: req=3'b111 held, each job len=0, out_done returned 2 cycles after the last word. Grant order is 0,1,2,0; no producer starves.
- Non-granted traffic: producer 2 asserts req_wr_en while producer 0 holds the grant → out_din carries only producer-0 data; out_wr_en count = 1 + out_len.
- Overflow: granted producer with len=1 sends 3 words → 2 forwarded, overflow pulses once, req_done still issued after out_done.
- Timeout: out_done never asserted, TIMEOUT=16 (override) → timeout_err pulses 16 cycles after WAIT_DONE is entered, then req_done pulses and the arbiter returns to IDLE.
- Reset mid-STREAM: rst_n low after 2 of 5 words → grant, busy and out_wr_en are 0 immediately. After release, a fresh request is granted starting from producer 0.

Source files
------------

// File: rtl/output_write_arbiter_if.sv
// Producer-side and writer-side signals of the output-DMA write arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface output_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 11,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        req_done;
    logic [LEN_W-1:0]          out_len;
    logic [ADDR_W-1:0]         out_base_addr;
    logic                      out_wr_en;
    logic [DATA_W-1:0]         out_din;
    logic                      out_done;
    logic                      busy;
    logic                      overflow;
    logic                      timeout_err;

    modport master (
        output req, req_len, req_addr, req_wr_en, req_din, out_done,
        input  grant, req_done, out_len, out_base_addr,
        input  out_wr_en, out_din, busy, overflow, timeout_err
    );

    modport slave (
        input  req, req_len, req_addr, req_wr_en, req_din, out_done,
        output grant, req_done, out_len, out_base_addr,
        output out_wr_en, out_din, busy, overflow, timeout_err
    );
endinterface

// File: rtl/output_write_arbiter.sv
// Round-robin arbiter sharing one output-DMA burst writer between producers.
// Latches the winner's job descriptor and forwards its words one cycle late.
module output_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 11,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 65535
) (
    input logic                   clk,
    input logic                   rst_n,
    output_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_DONE,
        RELEASE
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;

    logic [NUM_REQ-1:0]  req_avail;
    logic                found;
    logic [PTR_W-1:0]    pick;
    logic [CW-1:0]       cand;
    logic                g_wr_en;
    logic [DATA_W-1:0]   g_din;

    // A producer just acknowledged still holds req for this one cycle
    assign req_avail = bus.req & ~done_q;
    assign g_wr_en   = bus.req_wr_en[gidx_q];
    assign g_din     = bus.req_din[gidx_q*DATA_W +: DATA_W];

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!found && req_avail[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        wr_en_d  = 1'b0;
        din_d    = din_q;
        done_d   = '0;
        ovf_d    = 1'b0;
        tmo_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    len_d   = bus.req_len[pick*LEN_W +: LEN_W];
                    addr_d  = bus.req_addr[pick*ADDR_W +: ADDR_W];
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (g_wr_en) begin
                    wr_en_d = 1'b1;
                    din_d   = g_din;
                    // Hold the count on the last word so a full-size job never wraps
                    if (cnt_q == len_q) begin
                        state_d = WAIT_DONE;
                        timer_d = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            WAIT_DONE: begin
                ovf_d = g_wr_en;
                if (bus.out_done) begin
                    state_d = RELEASE;
                end else if (timer_q == TMR_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RELEASE: begin
                done_d   = grant_q;
                grant_d  = '0;
                rr_ptr_d = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
            done_q   <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.req_done      = done_q;
    assign bus.out_len       = len_q;
    assign bus.out_base_addr = addr_q;
    assign bus.out_wr_en     = wr_en_q;
    assign bus.out_din       = din_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.overflow      = ovf_q;
    assign bus.timeout_err   = tmo_q;

    // Writer must not report done before the last word was handed over
    a_no_done_in_stream: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(state_q == STREAM && bus.out_done)
    );

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q)
    );
endmodule

// File: tb/tb_output_write_arbiter.sv
// Directed bench for output_write_arbiter: arbitration, forwarding,
// overflow, timeout and asynchronous reset behaviour.
module tb_output_write_arbiter;
    localparam int NR = 3;
    localparam int LW = 11;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    output_write_arbiter_if #(
        .NUM_REQ(NR), .LEN_W(LW), .ADDR_W(AW), .DATA_W(DW)
    ) bus ();

    output_write_arbiter #(
        .NUM_REQ(NR), .LEN_W(LW), .ADDR_W(AW),
        .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    task automatic idle_inputs;
        bus.req       = '0;
        bus.req_len   = '0;
        bus.req_addr  = '0;
        bus.req_wr_en = '0;
        bus.req_din   = '0;
        bus.out_done  = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.out_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl got grant=%b busy=%b wr=%b exp 0",
                     bus.grant, bus.busy, bus.out_wr_en);
        end
        total++;
        if (bus.out_len !== '0 || bus.out_base_addr !== '0 || bus.req_done !== '0) begin
            bad++;
            $display("FAIL reset_data got len=%h addr=%h done=%b exp 0",
                     bus.out_len, bus.out_base_addr, bus.req_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [DW-1:0] d [4];
        d[0] = 32'hD000_0000;
        d[1] = 32'hD111_1111;
        d[2] = 32'hD222_2222;
        d[3] = 32'hD333_3333;
        @(negedge clk);
        bus.req[1] = 1'b1;
        bus.req_len[LW +: LW] = 11'd3;
        bus.req_addr[AW +: AW] = 32'h0000_1000;
        @(negedge clk);
        total++;
        if (bus.grant !== 3'b010 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got=%b busy=%b exp=010 busy=1",
                     bus.grant, bus.busy);
        end
        total++;
        if (bus.out_len !== 11'd3 || bus.out_base_addr !== 32'h1000) begin
            bad++;
            $display("FAIL single_desc got len=%h addr=%h exp len=3 addr=1000",
                     bus.out_len, bus.out_base_addr);
        end
        total++;
        if (bus.out_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL single_early_wr got=%b exp=0", bus.out_wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_wr_en[1] = 1'b1;
            bus.req_din[DW +: DW] = d[i];
            if (i == 1) begin
                bus.req_len[LW +: LW] = 11'd7;
                bus.req_addr[AW +: AW] = 32'h0;
            end
            @(negedge clk);
            total++;
            if (bus.out_wr_en !== 1'b1 || bus.out_din !== d[i]) begin
                bad++;
                $display("FAIL single_word%0d got wr=%b din=%h exp wr=1 din=%h",
                         i, bus.out_wr_en, bus.out_din, d[i]);
            end
        end
        total++;
        if (bus.out_len !== 11'd3 || bus.out_base_addr !== 32'h1000) begin
            bad++;
            $display("FAIL single_latch got len=%h addr=%h exp len=3 addr=1000",
                     bus.out_len, bus.out_base_addr);
        end
        bus.req_wr_en = '0;
        bus.out_done = 1'b1;
        @(negedge clk);
        bus.out_done = 1'b0;
        total++;
        if (bus.req_done !== 3'b000 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_release got done=%b busy=%b exp done=000 busy=1",
                     bus.req_done, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.req_done !== 3'b010 || bus.busy !== 1'b0 || bus.grant !== '0) begin
            bad++;
            $display("FAIL single_done got done=%b busy=%b grant=%b exp 010/0/000",
                     bus.req_done, bus.busy, bus.grant);
        end
        bus.req = '0;
        @(negedge clk);
        total++;
        if (bus.req_done !== 3'b000) begin
            bad++;
            $display("FAIL single_pulse got=%b exp=000", bus.req_done);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp_g [4];
        logic [AW-1:0] exp_a [4];
        logic [DW-1:0] wd;
        int n;
        exp_g[0] = 3'b001; exp_a[0] = 32'h0000_1000;
        exp_g[1] = 3'b010; exp_a[1] = 32'h0000_2000;
        exp_g[2] = 3'b100; exp_a[2] = 32'h0000_3000;
        exp_g[3] = 3'b001; exp_a[3] = 32'h0000_1000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_len = '0;
        bus.req_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (bus.grant === '0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (bus.grant !== exp_g[k] || bus.out_base_addr !== exp_a[k]) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b addr=%h exp=%b addr=%h",
                         k, bus.grant, bus.out_base_addr, exp_g[k], exp_a[k]);
            end
            wd = 32'h0000_0B00 + DW'(k);
            bus.req_wr_en = bus.grant;
            bus.req_din = {NR{wd}};
            @(negedge clk);
            bus.req_wr_en = '0;
            total++;
            if (bus.out_wr_en !== 1'b1 || bus.out_din !== wd) begin
                bad++;
                $display("FAIL rr_word%0d got wr=%b din=%h exp wr=1 din=%h",
                         k, bus.out_wr_en, bus.out_din, wd);
            end
            @(negedge clk);
            bus.out_done = 1'b1;
            @(negedge clk);
            bus.out_done = 1'b0;
            n = 0;
            while (bus.req_done === '0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (bus.req_done !== exp_g[k]) begin
                bad++;
                $display("FAIL rr_done%0d got=%b exp=%b", k, bus.req_done, exp_g[k]);
            end
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_non_granted;
        int cnt;
        int ov;
        int n;
        @(negedge clk);
        bus.req = 3'b001;
        bus.req_len[0 +: LW] = 11'd2;
        bus.req_addr[0 +: AW] = 32'h0000_4000;
        bus.req_wr_en[2] = 1'b1;
        bus.req_din[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (bus.grant !== 3'b001) begin
            bad++;
            $display("FAIL ng_grant got=%b exp=001", bus.grant);
        end
        cnt = 0;
        ov = 0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                bus.req_wr_en[0] = 1'b1;
                bus.req_din[0 +: DW] = 32'h0000_00C0 + DW'(c);
            end else begin
                bus.req_wr_en[0] = 1'b0;
            end
            @(negedge clk);
            if (bus.overflow === 1'b1) ov++;
            if (bus.out_wr_en === 1'b1) begin
                total++;
                if (bus.out_din !== 32'h0000_00C0 + DW'(cnt)) begin
                    bad++;
                    $display("FAIL ng_data%0d got=%h exp=%h",
                             cnt, bus.out_din, 32'h0000_00C0 + DW'(cnt));
                end
                cnt++;
            end
        end
        total++;
        if (cnt != 3 || ov != 0) begin
            bad++;
            $display("FAIL ng_count got wr=%0d ovf=%0d exp wr=3 ovf=0", cnt, ov);
        end
        bus.out_done = 1'b1;
        @(negedge clk);
        bus.out_done = 1'b0;
        n = 0;
        while (bus.req_done === '0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_done !== 3'b001) begin
            bad++;
            $display("FAIL ng_done got=%b exp=001", bus.req_done);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow;
        int cnt;
        int ov;
        int n;
        @(negedge clk);
        bus.req = 3'b010;
        bus.req_len[LW +: LW] = 11'd1;
        bus.req_addr[AW +: AW] = 32'h0000_6000;
        @(negedge clk);
        total++;
        if (bus.grant !== 3'b010) begin
            bad++;
            $display("FAIL ovf_grant got=%b exp=010", bus.grant);
        end
        cnt = 0;
        ov = 0;
        for (int c = 0; c < 5; c++) begin
            bus.req_wr_en[1] = (c < 3);
            bus.req_din[DW +: DW] = 32'h0000_00E0 + DW'(c);
            @(negedge clk);
            if (bus.overflow === 1'b1) ov++;
            if (bus.out_wr_en === 1'b1) cnt++;
        end
        total++;
        if (cnt != 2 || ov != 1) begin
            bad++;
            $display("FAIL ovf_count got wr=%0d ovf=%0d exp wr=2 ovf=1", cnt, ov);
        end
        bus.out_done = 1'b1;
        @(negedge clk);
        bus.out_done = 1'b0;
        n = 0;
        while (bus.req_done === '0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_done !== 3'b010) begin
            bad++;
            $display("FAIL ovf_done got=%b exp=010", bus.req_done);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        bus.req = 3'b010;
        bus.req_len[LW +: LW] = 11'd4;
        bus.req_addr[AW +: AW] = 32'h0000_5000;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            bus.req_wr_en[1] = 1'b1;
            bus.req_din[DW +: DW] = 32'h0000_0F00 + DW'(c);
            @(negedge clk);
        end
        total++;
        if (bus.out_wr_en !== 1'b1 || bus.grant !== 3'b010) begin
            bad++;
            $display("FAIL rst_pre got wr=%b grant=%b exp wr=1 grant=010",
                     bus.out_wr_en, bus.grant);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.out_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got grant=%b busy=%b wr=%b exp 0",
                     bus.grant, bus.busy, bus.out_wr_en);
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.req_done !== '0) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rst_no_done got=%0d exp=0", n);
        end
        bus.req_wr_en = '0;
        bus.req_len = '0;
        bus.req = 3'b111;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.grant !== 3'b001) begin
            bad++;
            $display("FAIL rst_regrant got=%b exp=001", bus.grant);
        end
        bus.req = 3'b001;
        bus.req_wr_en[0] = 1'b1;
        bus.req_din[0 +: DW] = 32'h0000_0077;
        @(negedge clk);
        bus.req_wr_en = '0;
        @(negedge clk);
        bus.out_done = 1'b1;
        @(negedge clk);
        bus.out_done = 1'b0;
        n = 0;
        while (bus.req_done === '0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_done !== 3'b001) begin
            bad++;
            $display("FAIL rst_done got=%b exp=001", bus.req_done);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        @(negedge clk);
        bus.req = 3'b100;
        bus.req_len[2*LW +: LW] = 11'd0;
        bus.req_addr[2*AW +: AW] = 32'h0000_7000;
        @(negedge clk);
        total++;
        if (bus.grant !== 3'b100) begin
            bad++;
            $display("FAIL tmo_grant got=%b exp=100", bus.grant);
        end
        bus.req_wr_en[2] = 1'b1;
        bus.req_din[2*DW +: DW] = 32'h0000_0099;
        @(negedge clk);
        bus.req_wr_en = '0;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != TO || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_delay got=%0d busy=%b exp=%0d busy=1", n, bus.busy, TO);
        end
        @(negedge clk);
        total++;
        if (bus.timeout_err !== 1'b0 || bus.req_done !== 3'b100 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_release got tmo=%b done=%b busy=%b exp 0/100/0",
                     bus.timeout_err, bus.req_done, bus.busy);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_non_granted();
        test_overflow();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
